// File: rtl/dmem_arbiter.sv
// dmem_arbiter: three-master round-robin arbiter for the data memory port.
// Grants are registered and one-hot (or zero); after each ownership ends the
// bus sits idle for one turnaround cycle before the next arbitration.
// Optional feature: define DMEM_ARB_TIMEOUT_EN to limit how long an owner may
// keep the bus while another master is waiting (HOLD_MAX cycles).
module dmem_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] m_wr,
    input  logic [2:0] m_rd,
    input  logic [7:0] m_addr0,
    input  logic [7:0] m_addr1,
    input  logic [7:0] m_addr2,
    input  logic [7:0] m_dout0,
    input  logic [7:0] m_dout1,
    input  logic [7:0] m_dout2,
    output logic [2:0] grant,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_dout,
    output logic       mem_wr,
    output logic       mem_rd,
    output logic       owner_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RELEASE = 2'b10
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] grant_next;
    logic [1:0] last_owner;
    logic [1:0] last_owner_next;
    logic [1:0] winner;
    logic [2:0] winner_onehot;
    logic       owner_req;
    logic       timeout_hit;

    // While busy, grant is the owner's one-hot mask, so it doubles as the
    // selector for the owner's own request bit.
    assign owner_req = |(req & grant);

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_next;
    logic       other_req;

    assign other_req   = |(req & ~grant);
    assign timeout_hit = (hold_cnt == HOLD_LAST) && other_req;

    // Hold counter: zero on entry to BUSY, counts each BUSY cycle, saturates.
    always_comb begin
        hold_cnt_next = 8'd0;
        if (state == BUSY && state_next == BUSY) begin
            hold_cnt_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 8'd1;
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt_next;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin pick: search starts just after the previous owner and wraps.
    always_comb begin
        winner = 2'd0;
        case (last_owner)
            2'd0: begin
                if (req[1])      winner = 2'd1;
                else if (req[2]) winner = 2'd2;
                else             winner = 2'd0;
            end
            2'd1: begin
                if (req[2])      winner = 2'd2;
                else if (req[0]) winner = 2'd0;
                else             winner = 2'd1;
            end
            default: begin
                if (req[0])      winner = 2'd0;
                else if (req[1]) winner = 2'd1;
                else             winner = 2'd2;
            end
        endcase
        case (winner)
            2'd0:    winner_onehot = 3'b001;
            2'd1:    winner_onehot = 3'b010;
            default: winner_onehot = 3'b100;
        endcase
    end

    // FSM next state, next grant and owner bookkeeping.
    always_comb begin
        state_next      = IDLE;
        grant_next      = 3'b000;
        last_owner_next = last_owner;
        case (state)
            IDLE: begin
                if (req != 3'b000) begin
                    state_next      = BUSY;
                    grant_next      = winner_onehot;
                    last_owner_next = winner;
                end
            end
            BUSY: begin
                if (owner_req && !timeout_hit) begin
                    state_next = BUSY;
                    grant_next = grant;
                end else begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, grant and last-owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 3'b000;
            last_owner <= 2'd2;
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            last_owner <= last_owner_next;
        end
    end

    // Memory-side mux of the granted master; write wins over read.
    always_comb begin
        mem_addr = 8'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        mem_rd   = 1'b0;
        case (grant)
            3'b001: begin
                mem_addr = m_addr0;
                mem_dout = m_dout0;
                mem_wr   = m_wr[0];
                mem_rd   = m_rd[0] & ~m_wr[0];
            end
            3'b010: begin
                mem_addr = m_addr1;
                mem_dout = m_dout1;
                mem_wr   = m_wr[1];
                mem_rd   = m_rd[1] & ~m_wr[1];
            end
            3'b100: begin
                mem_addr = m_addr2;
                mem_dout = m_dout2;
                mem_wr   = m_wr[2];
                mem_rd   = m_rd[2] & ~m_wr[2];
            end
            default: begin
                mem_addr = 8'd0;
            end
        endcase
    end

    assign owner_valid = |grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic for dmem_arbiter,
// compared against a cycle-level ownership model of the arbitration rules.
module tb_dmem_arbiter;

    localparam int HOLD_MAX = 8;

    logic       clk;
    logic       rst;
    logic [2:0] req;
    logic [2:0] m_wr;
    logic [2:0] m_rd;
    logic [7:0] addr_tb [3];
    logic [7:0] dout_tb [3];
    logic [2:0] grant;
    logic [7:0] mem_addr;
    logic [7:0] mem_dout;
    logic       mem_wr;
    logic       mem_rd;
    logic       owner_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: current owner (-1 = none), last owner, cycles held,
    // and whether a turnaround cycle is pending.
    int m_own  = -1;
    int m_last = 2;
    int m_held = 0;
    bit m_rel  = 1'b0;

    dmem_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .m_wr        (m_wr),
        .m_rd        (m_rd),
        .m_addr0     (addr_tb[0]),
        .m_addr1     (addr_tb[1]),
        .m_addr2     (addr_tb[2]),
        .m_dout0     (dout_tb[0]),
        .m_dout1     (dout_tb[1]),
        .m_dout2     (dout_tb[2]),
        .grant       (grant),
        .mem_addr    (mem_addr),
        .mem_dout    (mem_dout),
        .mem_wr      (mem_wr),
        .mem_rd      (mem_rd),
        .owner_valid (owner_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [2:0] ownMask(input int o);
        case (o)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    // Advance the ownership model by one clock using the sampled rst/req.
    task automatic modelStep(input logic r, input logic [2:0] rq);
        logic [2:0] om;
        om = ownMask(m_own);
        if (r) begin
            m_own  = -1;
            m_last = 2;
            m_held = 0;
            m_rel  = 1'b0;
        end else if (m_own >= 0) begin
            if ((rq & om) == 3'b000) begin
                m_own = -1;
                m_rel = 1'b1;
            end
`ifdef DMEM_ARB_TIMEOUT_EN
            else if (m_held >= HOLD_MAX && (rq & ~om) != 3'b000) begin
                m_own = -1;
                m_rel = 1'b1;
            end
`endif
            else if (m_held < HOLD_MAX) begin
                m_held++;
            end
        end else if (m_rel) begin
            m_rel = 1'b0;
        end else if (rq != 3'b000) begin
            for (int k = 1; k <= 3; k++) begin
                int idx;
                idx = (m_last + k) % 3;
                if (m_own < 0 && (rq & ownMask(idx)) != 3'b000) begin
                    m_own  = idx;
                    m_last = idx;
                    m_held = 1;
                end
            end
        end
    endtask

    // Drive one cycle of rst/req at the falling edge, check all outputs
    // against the model, then clock both DUT and model.
    task automatic applyStimulus(input logic r, input logic [2:0] rq);
        logic [2:0] om;
        logic [7:0] ea;
        logic [7:0] ed;
        logic       ew;
        logic       er;
        rst = r;
        req = rq;
        #1;
        om = ownMask(m_own);
        case (m_own)
            0:       begin ea = addr_tb[0]; ed = dout_tb[0]; end
            1:       begin ea = addr_tb[1]; ed = dout_tb[1]; end
            2:       begin ea = addr_tb[2]; ed = dout_tb[2]; end
            default: begin ea = 8'd0;       ed = 8'd0;       end
        endcase
        ew = |(m_wr & om);
        er = (|(m_rd & om)) & ~ew;
        checkOutput("grant",       32'(grant),       32'(om));
        checkOutput("owner_valid", 32'(owner_valid), 32'(|om));
        checkOutput("mem_addr",    32'(mem_addr),    32'(ea));
        checkOutput("mem_dout",    32'(mem_dout),    32'(ed));
        checkOutput("mem_wr",      32'(mem_wr),      32'(ew));
        checkOutput("mem_rd",      32'(mem_rd),      32'(er));
        @(posedge clk);
        modelStep(r, rq);
        @(negedge clk);
    endtask

    task automatic randomData();
        for (int i = 0; i < 3; i++) begin
            addr_tb[i] = 8'($urandom);
            dout_tb[i] = 8'($urandom);
        end
        m_wr = 3'($urandom);
        m_rd = 3'($urandom);
    endtask

    initial begin
        int         hold_len;
        logic [2:0] rq;

        rst  = 1'b1;
        req  = 3'b000;
        m_wr = 3'b000;
        m_rd = 3'b000;
        for (int i = 0; i < 3; i++) begin
            addr_tb[i] = 8'd0;
            dout_tb[i] = 8'd0;
        end
        @(negedge clk);
        applyStimulus(1'b1, 3'b000);

        // Rotation: 001, then 010, 100, 001 as each owner lets go.
        applyStimulus(1'b0, 3'b111);
        checkOutput("rot_first", 32'(grant), 32'(3'b001));
        applyStimulus(1'b0, 3'b110);
        applyStimulus(1'b0, 3'b111);
        applyStimulus(1'b0, 3'b111);
        checkOutput("rot_second", 32'(grant), 32'(3'b010));
        applyStimulus(1'b0, 3'b101);
        applyStimulus(1'b0, 3'b111);
        applyStimulus(1'b0, 3'b111);
        checkOutput("rot_third", 32'(grant), 32'(3'b100));
        applyStimulus(1'b0, 3'b011);
        applyStimulus(1'b0, 3'b111);
        applyStimulus(1'b0, 3'b111);
        checkOutput("rot_wrap", 32'(grant), 32'(3'b001));

        // Master 1 owns the bus; master 0 strobes must not leak through.
        applyStimulus(1'b1, 3'b000);
        addr_tb[0] = 8'h11;
        dout_tb[0] = 8'h22;
        addr_tb[1] = 8'hFE;
        dout_tb[1] = 8'h2A;
        m_wr = 3'b001;
        m_rd = 3'b001;
        applyStimulus(1'b0, 3'b010);
        #1;
        checkOutput("m0_wr_blocked", 32'(mem_wr), 32'(1'b0));
        checkOutput("m0_rd_blocked", 32'(mem_rd), 32'(1'b0));
        m_wr = 3'b011;
        m_rd = 3'b000;
        #1;
        checkOutput("m1_addr", 32'(mem_addr), 32'(8'hFE));
        checkOutput("m1_dout", 32'(mem_dout), 32'(8'h2A));
        checkOutput("m1_wr",   32'(mem_wr),   32'(1'b1));
        m_wr = 3'b010;
        m_rd = 3'b010;
        #1;
        checkOutput("wr_wins_wr", 32'(mem_wr), 32'(1'b1));
        checkOutput("wr_wins_rd", 32'(mem_rd), 32'(1'b0));
        applyStimulus(1'b0, 3'b010);

        // Reset while master 1 writes drops everything; last owner back to 2.
        applyStimulus(1'b1, 3'b110);
        checkOutput("rst_grant",  32'(grant),  32'(3'b000));
        checkOutput("rst_mem_wr", 32'(mem_wr), 32'(1'b0));
        applyStimulus(1'b0, 3'b110);
        checkOutput("post_rst_grant", 32'(grant), 32'(3'b010));

        // Master 0 holds with master 2 waiting: bounded by HOLD_MAX only
        // when the timeout feature is built in.
        applyStimulus(1'b1, 3'b000);
        hold_len = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 3'b101);
            if (grant == 3'b001) hold_len++;
        end
`ifdef DMEM_ARB_TIMEOUT_EN
        checkOutput("hold_len", 32'(hold_len), 32'(HOLD_MAX));
        checkOutput("hold_next", 32'(grant), 32'(3'b100));
`else
        checkOutput("hold_len", 32'(hold_len), 32'd14);
`endif

        // No requests at all: bus stays quiet whatever the masters drive.
        applyStimulus(1'b1, 3'b000);
        for (int i = 0; i < 10; i++) begin
            randomData();
            applyStimulus(1'b0, 3'b000);
        end

        // Randomized traffic with sticky requests and occasional resets.
        rq = 3'b000;
        for (int i = 0; i < 600; i++) begin
            randomData();
            rq = rq ^ (3'($urandom) & 3'($urandom) & 3'($urandom));
            applyStimulus(($urandom_range(0, 60) == 0) ? 1'b1 : 1'b0, rq);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
